// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_mc_pkg: state, opcode and ALU encodings for the multicycle core |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_ILLEGAL  = 4'd9
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_control_unit_if: controller <-> datapath/memory signals   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface multicycle_control_unit_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic       InputSRC;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7_5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, InputSRC, illegal, state
  );

  modport slave (
    output op, funct3, funct7_5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, InputSRC, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_alu_decoder: maps ALUOp/funct fields to an ALUControl code        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mc_alu_decoder
  import riscv_mc_pkg::*;
(
  input  wire logic [1:0] i_alu_op,
  input  wire logic [2:0] i_funct3,
  input  wire logic       i_op5,
  input  wire logic       i_funct7_5,
  output logic      [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 && i_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          3'b101:  o_alu_control = i_funct7_5 ? ALU_SRA : ALU_ADD;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_control_unit: Moore FSM sequencing lw/sw/R-type/beq       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multicycle_control_unit
  import riscv_mc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  multicycle_control_unit_if.master bus
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_reg_write;
  logic [1:0] w_alu_op;
  logic       w_input_src;
  logic       w_illegal;
  logic [1:0] w_imm_src;
  logic [2:0] w_alu_control;
  logic       w_is_input_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      r_state <= w_next_state;
    end
  end

  assign w_is_input_load = (bus.op == OP_LW) && (bus.funct3 == 3'b111);

  always_comb begin
    w_next_state = S_FETCH;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_reg_write  = 1'b0;
    w_alu_op     = ALUOP_ADD;
    w_input_src  = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here from OldPC + ImmExt.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXECR;
          OP_BEQ:       w_next_state = S_BEQ;
          default:      w_next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b01;
        w_next_state = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr_src    = 1'b1;
        w_input_src  = w_is_input_load;
        w_next_state = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_input_src  = w_is_input_load;
      end
      S_MEMWRITE: begin
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_next_state = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_alu_src_a  = 2'b10;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = ALUOP_SUB;
        w_pc_write  = bus.Zero;
      end
      S_ILLEGAL: begin
        w_illegal    = 1'b1;
        w_next_state = S_ILLEGAL;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_LW:   w_imm_src = 2'b00;
      OP_SW:   w_imm_src = 2'b01;
      OP_BEQ:  w_imm_src = 2'b10;
      default: w_imm_src = 2'b00;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (bus.funct3),
    .i_op5         (bus.op[5]),
    .i_funct7_5    (bus.funct7_5),
    .o_alu_control (w_alu_control)
  );

  // Strobes are gated by rst_n so they drop the instant reset asserts.
  assign bus.PCWrite    = w_pc_write  & rst_n;
  assign bus.IRWrite    = w_ir_write  & rst_n;
  assign bus.RegWrite   = w_reg_write & rst_n;
  assign bus.MemWrite   = w_mem_write & rst_n;
  assign bus.illegal    = w_illegal   & rst_n;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.ImmSrc     = w_imm_src;
  assign bus.ALUControl = w_alu_control;
  assign bus.InputSRC   = w_input_src;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_control_unit: scoreboard bench for the control FSM     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_multicycle_control_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.RESET_STATE(4'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic [21:0] exp;
  } entry_t;

  entry_t sbq[$];

  // Strobe bits within the 22-bit observation: PCWrite, MemWrite, IRWrite, RegWrite, illegal.
  localparam logic [21:0] STROBE_MASK = 22'h02C021;

  function automatic logic [21:0] obs();
    return {bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite,
            bus.ALUControl, bus.InputSRC, bus.illegal};
  endfunction

  // Reference outputs for a state, written from the state/field tables.
  function automatic logic [17:0] model(input logic [3:0] st, input logic [6:0] op,
                                        input logic [2:0] f3, input logic f7,
                                        input logic z, input logic mr);
    logic pcw, adr, memw, irw, regw, insrc, ill;
    logic [1:0] res, sa, sb, imm, aop;
    logic [2:0] aluc;
    pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; insrc = 0; ill = 0;
    res = 0; sa = 0; sb = 0; aop = 0;
    case (st)
      4'd0: begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      4'd1: begin sa = 2'b01; sb = 2'b01; end
      4'd2: begin sa = 2'b10; sb = 2'b01; end
      4'd3: begin adr = 1; insrc = (op == 7'b0000011) && (f3 == 3'b111); end
      4'd4: begin res = 2'b01; regw = 1; insrc = (op == 7'b0000011) && (f3 == 3'b111); end
      4'd5: begin adr = 1; memw = 1; end
      4'd6: begin sa = 2'b10; aop = 2'b10; end
      4'd7: regw = 1;
      4'd8: begin sa = 2'b10; aop = 2'b01; pcw = z; end
      4'd9: ill = 1;
      default: ;
    endcase
    if (op == 7'b0100011)      imm = 2'b01;
    else if (op == 7'b1100011) imm = 2'b10;
    else                       imm = 2'b00;
    if (aop == 2'b01) aluc = 3'b001;
    else if (aop == 2'b10) begin
      if (f3 == 3'b000)      aluc = (op[5] && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) aluc = 3'b101;
      else if (f3 == 3'b110) aluc = 3'b011;
      else if (f3 == 3'b111) aluc = 3'b010;
      else if (f3 == 3'b101) aluc = f7 ? 3'b110 : 3'b000;
      else                   aluc = 3'b000;
    end else aluc = 3'b000;
    return {pcw, adr, memw, irw, res, sa, sb, imm, regw, aluc, insrc, ill};
  endfunction

  task automatic push(input logic [3:0] st, input logic mr);
    entry_t e;
    e.mr  = mr;
    e.exp = {st, model(st, bus.op, bus.funct3, bus.funct7_5, bus.Zero, mr)};
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    logic [21:0] got, exp;
    rst_n = 1'b0;
    bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7_5 = 1'b0;
    bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    #12;
    got = obs();
    exp = {4'd0, model(4'd0, bus.op, bus.funct3, bus.funct7_5, bus.Zero, 1'b1)} & ~STROBE_MASK;
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", got, exp);
    end
    bus.mem_ready = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    entry_t e; logic [21:0] got; int n = 0;
    bus.op = 7'b0000011; bus.funct3 = 3'b010;
    push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(4, 1); push(0, 0);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      bus.mem_ready = e.mr;
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL lw cyc%0d: got %h expected %h", n, got, e.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    entry_t e; logic [21:0] got; int n = 0;
    bus.op = 7'b0100011; bus.funct3 = 3'b010;
    push(0, 1); push(1, 1); push(2, 1); push(5, 0); push(5, 0); push(5, 1); push(0, 0);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      bus.mem_ready = e.mr;
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL sw cyc%0d: got %h expected %h", n, got, e.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    entry_t e; logic [21:0] got; int n = 0;
    logic [3:0] tbl [4];
    tbl[0] = 4'b000_1; tbl[1] = 4'b101_1; tbl[2] = 4'b110_0; tbl[3] = 4'b010_0;
    bus.op = 7'b0110011;
    for (int k = 0; k < 4; k++) begin
      bus.funct3 = tbl[k][3:1]; bus.funct7_5 = tbl[k][0];
      push(0, 1); push(1, 1); push(6, 1); push(7, 1);
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        bus.mem_ready = e.mr;
        @(negedge clk);
        got = obs();
        vectors++;
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL rtype%0d cyc%0d: got %h expected %h", k, n, got, e.exp);
        end
        n++;
        @(posedge clk); #1;
      end
    end
    bus.mem_ready = 1'b0;
    bus.funct7_5 = 1'b0;
  endtask

  task automatic test_beq();
    entry_t e; logic [21:0] got; int n = 0;
    bus.op = 7'b1100011; bus.funct3 = 3'b000;
    for (int z = 1; z >= 0; z--) begin
      bus.Zero = z[0];
      push(0, 0); push(0, 1); push(1, 1); push(8, 1); push(0, 0);
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        bus.mem_ready = e.mr;
        @(negedge clk);
        got = obs();
        vectors++;
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL beq_z%0d cyc%0d: got %h expected %h", z, n, got, e.exp);
        end
        n++;
        @(posedge clk); #1;
      end
    end
    bus.Zero = 1'b0;
  endtask

  task automatic test_illegal();
    entry_t e; logic [21:0] got; int n = 0;
    bus.op = 7'b0010011; bus.funct3 = 3'b000;
    push(0, 1); push(1, 1);
    for (int i = 0; i < 10; i++) push(9, 1);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      bus.mem_ready = e.mr;
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL illegal cyc%0d: got %h expected %h", n, got, e.exp);
      end
      n++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.state !== 4'd0 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_reset: got state=%0d illegal=%b expected state=0 illegal=0",
               bus.state, bus.illegal);
    end
    bus.mem_ready = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midread();
    entry_t e; logic [21:0] got, exp; int n = 0;
    bus.op = 7'b0000011; bus.funct3 = 3'b111;
    push(0, 1); push(1, 1); push(2, 1); push(3, 0);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      bus.mem_ready = e.mr;
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL midread cyc%0d: got %h expected %h", n, got, e.exp);
      end
      n++;
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    got = obs();
    exp = {4'd0, model(4'd0, bus.op, bus.funct3, bus.funct7_5, bus.Zero, 1'b1)} & ~STROBE_MASK;
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", got, exp);
    end
    bus.mem_ready = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(4, 1); push(0, 0);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      bus.mem_ready = e.mr;
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL post_reset cyc%0d: got %h expected %h", n, got, e.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_illegal();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Main controller for the multicycle RISC-V core, supporting lw, sw, R-type and beq. It sequences the shared-memory datapath (one ALU, one memory port, IR and PC registers) through a Moore FSM. Instruction and data accesses are handshaked with the memory through a mem_ready input, and any unsupported opcode is trapped.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); fixed, not overridden in the core.

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  opcode from the instruction register
funct3  in  3  funct3 from the instruction register
funct7_5  in  1  instruction bit 30
Zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction and OldPC register enable
ResultSrc  out  2  result mux select: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1 register
ALUSrcB  out  2  ALU B select: 00=rs2 register, 01=ImmExt, 10=constant 4
ImmSrc  out  2  immediate format select
RegWrite  out  1  register file write enable
ALUControl  out  3  ALU operation select
InputSRC  out  1  selects the input port instead of memory data
illegal  out  1  sticky flag for an unsupported opcode
state  out  4  current state, for debug

Behaviour:
- Reset: rst_n=0 forces state=FETCH (0) immediately and asynchronously. While reset is held, PCWrite, IRWrite, RegWrite, MemWrite and illegal are 0. All other outputs take their FETCH values.
- Outputs are combinational from state, op, funct3, funct7_5, Zero and mem_ready. No output is registered.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, BEQ=8, ILLEGAL=9.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which computes the branch target. Next state:
  - op=0000011 or 0100011 -> MEMADR
  - op=0110011 -> EXECR
  - op=1100011 -> BEQ
  - any other op -> ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD:
  - AdrSrc=1, ResultSrc=00.
  - Holds while mem_ready=0; goes to MEMWB when mem_ready=1.
- MEMWRITE:
  - AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle until mem_ready=1.
  - Goes to FETCH when mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- InputSRC=1 in MEMREAD and MEMWB when op=0000011 and funct3=111; otherwise 0.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite=Zero.
  - Then FETCH.
- ILLEGAL:
  - All write enables are 0 and illegal=1.
  - Terminal; only rst_n exits it.
- Defaults: any field not listed for a state is 0, and all strobes default to 0.
- ImmSrc is decoded from op in every state:
  - lw=00, sw=01, beq=10, otherwise 00.
- ALU decode:
  - ALUOp=00 -> 000 (add).
  - ALUOp=01 -> 001 (sub).
  - ALUOp=10 by funct3:
    - 000 -> 001 (sub) if {op[5],funct7_5}=11, else 000 (add).
    - 010 -> 101 (slt).
    - 110 -> 011 (or).
    - 111 -> 010 (and).
    - 101 -> 110 (sra) if funct7_5=1, else 000.
    - Any other funct3 -> 000.
- Per-instruction latency with mem_ready tied to 1: lw 5 cycles, sw 4, R-type 4, beq 3. Each cycle of mem_ready=0 adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Decoded state values 10..15 are unreachable. If entered, the next state is FETCH and all strobes are 0.

Decomposition:
- Package riscv_mc_pkg holds:
  - state encodings
  - opcode constants OP_LW, OP_SW, OP_R, OP_BEQ
  - ALUOp codes
  - ALUControl codes ADD=000, SUB=001, AND=010, OR=011, SLT=101, SRA=110
- One sub-module, mc_alu_decoder: purely combinational, inputs ALUOp, funct3, op[5], funct7_5; output ALUControl.
- The FSM (state register, next-state and output logic) stays in the top module.

Test Plan:
- lw, op=0000011, funct3=010, mem_ready=1 -> states 0,1,2,3,4,0. IRWrite=1 in cycle 0; RegWrite=1 with ResultSrc=01 in cycle 4; InputSRC=0 throughout.
- sw, op=0100011, mem_ready low 2 cycles in MEMWRITE -> MemWrite=1 for 3 consecutive cycles, ImmSrc=01, then FETCH.
- R-type sub (funct3=000, funct7_5=1) -> ALUControl=001 in EXECR. Then sra (funct3=101, funct7_5=1) -> ALUControl=110. RegWrite=1 in ALUWB only.
- beq with Zero=1 -> PCWrite=1 in BEQ. Repeat with Zero=0 -> PCWrite=0. Both cases back in FETCH after 3 cycles.
- op=0010011 -> DECODE->ILLEGAL, illegal=1, held for 10 cycles with all strobes 0. rst_n pulse returns state to 0.
- lw with funct3=111, rst_n asserted mid-MEMREAD -> InputSRC=1 in MEMREAD before the reset. On reset, state=0 and all strobes drop without waiting for a clock edge. After release, a clean fetch follows.
